uart_tx_arbiter: RTL

//   Shares the single UART transmitter (my_uart_tx + speed_setting pair) between NUM_REQ byte sources
//   (e.g. rx echo, display status reporter). Round-robin grant, one byte in flight, valid/ready per

---
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx core between NUM_REQ byte sources, one byte in flight.
// Define UART_ARB_FRAME_LOCK_EN to hold the grant on one requester until it sends a byte with req_last=1.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int BUSY_WAIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       arb_busy,
    output logic                       err_nostart
);
    localparam int                ID_W      = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]     NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
    localparam logic [3:0]        WAIT_LAST = 4'(BUSY_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wait_cnt;
    logic [NUM_REQ-1:0] eligible;
    logic [ID_W:0]     rr_sum;
    logic              sel_found;
    logic [ID_W-1:0]   sel_idx;
    logic [7:0]        sel_data;
    logic              accept;
    logic              timeout;

`ifdef UART_ARB_FRAME_LOCK_EN
    logic lock_active;
    logic sel_last;

    // While a frame is open only its owner (the current grant_id) may be chosen.
    always_comb begin
        eligible = req_valid;
        if (lock_active) begin
            eligible = req_valid & (NUM_REQ'(1) << grant_id);
        end
    end

    assign sel_last = req_last[sel_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_active <= 1'b0;
        end else if (accept) begin
            lock_active <= !sel_last;
        end else if (timeout) begin
            lock_active <= 1'b0;
        end
    end
`else
    logic unused_last;

    assign eligible    = req_valid;
    assign unused_last = ^req_last;
`endif

    // Scan grant_id+1, grant_id+2, ... modulo NUM_REQ; first eligible index wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = grant_id;
        rr_sum    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_sum = {1'b0, grant_id} + (ID_W + 1)'(k);
            if (rr_sum >= NUM_REQ_W) begin
                rr_sum = rr_sum - NUM_REQ_W;
            end
            if (!sel_found && eligible[rr_sum[ID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = rr_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == ID_W'(i)) begin
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        if (state == IDLE && !tx_busy && sel_found) begin
            req_ready[sel_idx] = 1'b1;
            accept             = 1'b1;
        end
    end

    assign timeout  = (state == WAIT_BUSY) && !tx_busy && (wait_cnt == WAIT_LAST);
    assign tx_start = (state == ISSUE);
    assign arb_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // A timed-out byte is dropped; err_nostart stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id    <= LAST_ID;
            tx_data     <= 8'h00;
            wait_cnt    <= 4'd0;
            err_nostart <= 1'b0;
        end else begin
            if (accept) begin
                tx_data  <= sel_data;
                grant_id <= sel_idx;
            end
            if (state == ISSUE) begin
                wait_cnt <= 4'd0;
            end else if (state == WAIT_BUSY && !tx_busy) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (timeout) begin
                err_nostart <= 1'b1;
            end
        end
    end
endmodule
